// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble controller for a 5-stage RISC-V pipeline
// Controls are combinational from state+inputs; state, wait counter, timeout flag and stall counter are registered.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic [1:0]       ctrl_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [15:0]      wait_cnt;
  logic             load_use;
  logic             mem_stall;

  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    state_nxt     = state;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble} = 5'b11111;
            state_nxt = MEM_WAIT;
          end else if (ex_mdu_start) begin
            {pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble} = 4'b1111;
            state_nxt = MDU_WAIT;
          end else if (ex_redirect) begin
            {if_id_flush, id_ex_flush} = 2'b11;
          end else if (load_use) begin
            {pc_stall, if_id_stall, id_ex_flush} = 3'b111;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble} = 5'b11111;
          end else begin
            state_nxt = RUN;
          end
        end
        MDU_WAIT: begin
          // a pending memory stall freezes MEM and keeps mdu_done unconsumed
          if (mem_stall) begin
            {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble} = 5'b11111;
          end else if (!mdu_done) begin
            {pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble} = 4'b1111;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= 16'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if ((state == RUN) && (state_nxt == MEM_WAIT)) begin
        wait_cnt <= 16'd0;
      end else if ((state == MEM_WAIT) && !mem_ready && (wait_cnt != TIMEOUT_LIM)) begin
        wait_cnt <= wait_cnt + 16'd1;
        if (wait_cnt == TIMEOUT_LIM - 16'd1) begin
          mem_timeout <= 1'b1;
        end
      end
    end
  end

  assign ctrl_state = state;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards, EX-stage control redirects, multi-cycle MDU (mul/div) operations and data-memory wait states.
- Drives the stall/flush/bubble controls of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Maintains a stall-cycle performance counter and a memory-timeout error flag.

Parameters:
MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles after which mem_timeout is set (range 1..65535).
CNT_W, 32, width of the stall_cycles counter.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
id_rs1  input  5  rs1 index of the instruction in ID
id_rs2  input  5  rs2 index of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  rd index of the instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_redirect  input  1  EX branch taken or jump (PC redirect this cycle)
ex_mdu_start  input  1  EX instruction is a multi-cycle MDU op (first EX cycle)
mdu_done  input  1  MDU result valid this cycle
mem_req  input  1  MEM instruction accesses data memory
mem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  load NOP (0x00000033) into IF/ID
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  load bubble into ID/EX
ex_mem_stall  output  1  hold EX/MEM
ex_mem_bubble  output  1  load bubble into EX/MEM
mem_wb_bubble  output  1  load bubble into MEM/WB
ctrl_state  output  2  current state: 0 RUN, 1 MEM_WAIT, 2 MDU_WAIT
mem_timeout  output  1  sticky error flag
stall_cycles  output  CNT_W  count of cycles with pc_stall=1, saturating

Behaviour:
- Reset (rst=1 at a rising edge): state RUN, stall_cycles=0, wait counter=0, mem_timeout=0. While rst=1, all stall/flush/bubble outputs are forced to 0 regardless of inputs. Reset mid-wait aborts the wait immediately.
- The control outputs are combinational functions of the current state and inputs, so they act in the same cycle. State, counters and the error flag are registered.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, conditions evaluated in priority order; the first match applies:
  1. mem_req & !mem_ready: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble; next state MEM_WAIT.
  2. ex_mdu_start: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble; next state MDU_WAIT. mdu_done is ignored in RUN, so the MDU takes a minimum of 2 EX cycles.
  3. ex_redirect: assert if_id_flush and id_ex_flush; stay in RUN. Redirect outranks load_use.
  4. load_use: assert pc_stall, if_id_stall, id_ex_flush (exactly one bubble); stay in RUN. The hazard clears the next cycle once the load reaches MEM.
  5. Otherwise: all controls 0.
- MEM_WAIT:
  - While !mem_ready: same freeze set as RUN case 1.
  - Cycle with mem_ready=1: all controls 0 and the pipeline advances; next state RUN.
  - All other inputs are ignored in this state.
- MDU_WAIT:
  - While !mdu_done: same set as RUN case 2.
  - Cycle with mdu_done=1: all controls 0; next state RUN.
  - ex_redirect and load_use are ignored.
  - mem_req & !mem_ready also takes priority here: freeze set of RUN case 1 is applied, state stays MDU_WAIT, and mdu_done is not consumed. The MDU holds done until the stall releases.
- Wait counter (16 bit):
  - Cleared on every entry to MEM_WAIT; incremented each MEM_WAIT cycle with !mem_ready.
  - When it reaches MEM_TIMEOUT, mem_timeout is set and stays 1 until rst. The controller remains in MEM_WAIT and the counter holds, with no wrap.
- stall_cycles increments on each cycle with pc_stall=1 and saturates at all-ones.
- No output toggles on x/z inputs during reset. Indices equal to 0 never generate a hazard.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_cycles=1; state stays 0.
- x0 / redirect priority: ex_rd=0 with load and matching rs -> no stall. Then ex_redirect=1 together with a valid load_use -> if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> freeze set for 3 cycles, ctrl_state=1 on cycles 2-3, all 0 on the ready cycle, RUN after; stall_cycles=3.
- MDU: ex_mdu_start=1, mdu_done on the 4th cycle -> pc_stall/ex_mem_bubble=1 for 3 cycles, ctrl_state=2, release on the done cycle. A redirect pulse during the wait is ignored.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th wait cycle and stays 1 after mem_ready; cleared only by rst.
- Reset mid-MDU_WAIT: rst=1 for 1 cycle -> all outputs 0 during rst, then ctrl_state=0, stall_cycles=0, mem_timeout=0.
